// File: rtl/cpu19_pkg.sv
// Shared definitions for the writeback path: widths, the writeback request
// record and the arbitration source encoding.
package cpu19_pkg;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 3;
  localparam int NREG   = 2 ** ADDR_W;

  // One writeback request as seen by the arbiter.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Identifies a requester; also used as the round-robin "last granted" pointer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU and memory writeback requests, destination reservation
// from issue, the register-file write port and the pending-write scoreboard.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = cpu19_pkg::DATA_W,
  parameter int ADDR_W = cpu19_pkg::ADDR_W,
  parameter int NREG   = cpu19_pkg::NREG
);

  logic              alu_valid_i;
  logic [ADDR_W-1:0] alu_rd_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_ready_o;

  logic              mem_valid_i;
  logic [ADDR_W-1:0] mem_rd_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ready_o;

  logic              rsv_valid_i;
  logic [ADDR_W-1:0] rsv_rd_i;

  logic              rf_wr_en_o;
  logic [ADDR_W-1:0] rf_rd_addr_o;
  logic [DATA_W-1:0] rf_wr_data_o;
  logic [NREG-1:0]   busy_o;
  logic              unrsv_err_o;

  // Requester / pipeline side.
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output mem_valid_i, mem_rd_i, mem_data_i,
    output rsv_valid_i, rsv_rd_i,
    input  alu_ready_o, mem_ready_o,
    input  rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o, busy_o, unrsv_err_o
  );

  // Arbiter side.
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  mem_valid_i, mem_rd_i, mem_data_i,
    input  rsv_valid_i, rsv_rd_i,
    output alu_ready_o, mem_ready_o,
    output rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o, busy_o, unrsv_err_o
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone request is granted immediately; when
// both request, the one not granted most recently wins. The pointer moves
// only when a grant is actually given.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  import cpu19_pkg::*;

  wb_src_e r_last;

  // Grant decode from the request pair and the last-granted pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (r_last == SRC_ALU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer register; reset claims MEM went last so ALU wins the first contest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      r_last <= SRC_MEM;
    end else if (|grant) begin
      r_last <= grant[1] ? SRC_MEM : SRC_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: picks one of the ALU / memory writeback
// requests per cycle, registers it onto the register-file write port, and
// tracks which destination registers still have a write outstanding.
module regfile_wb_arbiter #(
  parameter int DATA_W = cpu19_pkg::DATA_W,
  parameter int ADDR_W = cpu19_pkg::ADDR_W,
  parameter int NREG   = cpu19_pkg::NREG
) (
  input logic                 clk,
  input logic                 reset_n,
  regfile_wb_arbiter_if.slave bus
);
  import cpu19_pkg::*;

  localparam logic [NREG-1:0] ONE_BIT = {{(NREG-1){1'b0}}, 1'b1};

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_xfer;
  wb_req_t           w_alu_req;
  wb_req_t           w_mem_req;
  wb_req_t           w_sel;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_clr;
  logic [NREG-1:0]   w_busy_nxt;
  logic              w_unrsv_hit;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [NREG-1:0]   r_busy;
  logic              r_err;

  // Requests are masked by reset so both readies drop the instant reset asserts.
  assign w_req = {bus.mem_valid_i, bus.alu_valid_i} & {2{reset_n}};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (w_req),
    .grant   (w_grant)
  );

  assign bus.alu_ready_o = w_grant[0];
  assign bus.mem_ready_o = w_grant[1];
  assign w_xfer          = |w_grant;

  assign w_alu_req = '{rd: bus.alu_rd_i, data: bus.alu_data_i};
  assign w_mem_req = '{rd: bus.mem_rd_i, data: bus.mem_data_i};

  // Mux the granted request toward the write-port registers.
  always_comb begin
    w_sel = w_alu_req;
    if (w_grant[1]) w_sel = w_mem_req;
  end

  // Write-port registers: one cycle after a transfer; writes to r0 are swallowed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_xfer && (w_sel.rd != '0);
      if (w_xfer) begin
        r_rd_addr <= w_sel.rd;
        r_wr_data <= w_sel.data;
      end
    end
  end

  // Scoreboard next state: commit clears, reservation sets, set wins a tie, r0 never busy.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (bus.rsv_valid_i) w_set = ONE_BIT << bus.rsv_rd_i;
    if (r_wr_en)         w_clr = ONE_BIT << r_rd_addr;
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  // A commit landing on a register nobody reserved.
  assign w_unrsv_hit = r_wr_en && !r_busy[r_rd_addr];

  // Scoreboard and sticky unreserved-write flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_unrsv_hit) r_err <= 1'b1;
    end
  end

  assign bus.rf_wr_en_o   = r_wr_en;
  assign bus.rf_rd_addr_o = r_rd_addr;
  assign bus.rf_wr_data_o = r_wr_data;
  assign bus.busy_o       = r_busy;
  assign bus.unrsv_err_o  = r_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Stimulus pushes each expected
// register-file write into a queue; a monitor pops and compares whenever the
// write port is enabled. Handshake and scoreboard state are checked inline.
module tb_regfile_wb_arbiter;
  import cpu19_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  wb_req_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                        input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                        input logic rv, input logic [ADDR_W-1:0] rrd);
    bus.alu_valid_i = av;
    bus.alu_rd_i    = ard;
    bus.alu_data_i  = ad;
    bus.mem_valid_i = mv;
    bus.mem_rd_i    = mrd;
    bus.mem_data_i  = md;
    bus.rsv_valid_i = rv;
    bus.rsv_rd_i    = rrd;
  endtask

  task automatic check_state(input string name, input logic e_alu, input logic e_mem,
                             input logic e_wr, input logic [NREG-1:0] e_busy, input logic e_err);
    check($sformatf("%s_alu_ready", name), {31'd0, bus.alu_ready_o}, {31'd0, e_alu});
    check($sformatf("%s_mem_ready", name), {31'd0, bus.mem_ready_o}, {31'd0, e_mem});
    check($sformatf("%s_wr_en", name),     {31'd0, bus.rf_wr_en_o},  {31'd0, e_wr});
    check($sformatf("%s_busy", name),      32'(bus.busy_o),          32'(e_busy));
    check($sformatf("%s_unrsv_err", name), {31'd0, bus.unrsv_err_o}, {31'd0, e_err});
  endtask

  // One stimulus cycle: drive after the edge, check before the next edge, and
  // queue the writes the bench expects the grant to produce.
  task automatic cycle(input string name,
                       input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                       input logic rv, input logic [ADDR_W-1:0] rrd,
                       input logic e_alu, input logic e_mem, input logic e_wr,
                       input logic [NREG-1:0] e_busy, input logic e_err, input logic do_push);
    @(posedge clk);
    #1;
    set_in(av, ard, ad, mv, mrd, md, rv, rrd);
    #3;
    check_state(name, e_alu, e_mem, e_wr, e_busy, e_err);
    if (do_push && e_alu && ard != '0) exp_q.push_back('{rd: ard, data: ad});
    if (do_push && e_mem && mrd != '0) exp_q.push_back('{rd: mrd, data: md});
  endtask

  // Monitor: every enabled write must match the oldest expected write.
  initial begin
    wb_req_t e;
    forever begin
      @(negedge clk);
      if (bus.rf_wr_en_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_write: got addr %0h data %0h, required no write",
                   bus.rf_rd_addr_o, bus.rf_wr_data_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.rf_rd_addr_o), 32'(e.rd));
          check("wr_data", 32'(bus.rf_wr_data_o), 32'(e.data));
        end
      end
    end
  end

  initial begin
    // Reset with an ALU request already waiting: readies must stay low.
    reset_n = 1'b0;
    set_in(1'b1, 3'd3, 19'h1A5A5, 1'b0, 3'd0, 19'h0, 1'b1, 3'd3);
    #4;
    check_state("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("reset_addr", 32'(bus.rf_rd_addr_o), 32'h0);
    check("reset_data", 32'(bus.rf_wr_data_o), 32'h0);

    // Release between edges; the first edge after release carries the transfer.
    #18;
    reset_n = 1'b1;
    #2;
    check_state("first", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    exp_q.push_back('{rd: 3'd3, data: 19'h1A5A5});

    //     name   av ard  ad         mv mrd md         rv rrd  alu  mem  wr   busy   err  push
    cycle("c2",  0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     1, 3'd1, 0, 0, 1, 8'h08, 0, 1);
    cycle("c3",  0, 3'd0, 19'h0,     1, 3'd0, 19'h7FFFF, 1, 3'd2, 0, 1, 0, 8'h02, 0, 1);
    cycle("c4",  1, 3'd1, 19'h0AAAA, 1, 3'd2, 19'h05555, 0, 3'd0, 1, 0, 0, 8'h06, 0, 1);
    cycle("c5",  1, 3'd1, 19'h0AAAA, 1, 3'd2, 19'h05555, 0, 3'd0, 0, 1, 1, 8'h06, 0, 1);
    cycle("c6",  1, 3'd1, 19'h12345, 1, 3'd2, 19'h05555, 1, 3'd1, 1, 0, 1, 8'h04, 0, 1);
    cycle("c7",  1, 3'd1, 19'h12345, 1, 3'd2, 19'h54321, 1, 3'd2, 0, 1, 1, 8'h02, 0, 1);
    cycle("c8",  0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     0, 3'd0, 0, 0, 1, 8'h04, 0, 1);
    cycle("c9",  0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     1, 3'd5, 0, 0, 0, 8'h00, 0, 1);
    cycle("c10", 1, 3'd5, 19'h0C0DE, 0, 3'd0, 19'h0,     0, 3'd0, 1, 0, 0, 8'h20, 0, 1);
    cycle("c11", 0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     1, 3'd5, 0, 0, 1, 8'h20, 0, 1);
    cycle("c12", 1, 3'd6, 19'h06666, 0, 3'd0, 19'h0,     0, 3'd0, 1, 0, 0, 8'h20, 0, 1);
    cycle("c13", 0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     0, 3'd0, 0, 0, 1, 8'h20, 0, 1);
    cycle("c14", 0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     0, 3'd0, 0, 0, 0, 8'h20, 1, 1);
    cycle("c15", 0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     0, 3'd0, 0, 0, 0, 8'h20, 1, 1);
    // Granted write that reset will discard before it commits: not queued.
    cycle("c16", 1, 3'd4, 19'h04444, 0, 3'd0, 19'h0,     0, 3'd0, 1, 0, 0, 8'h20, 1, 0);

    // Reset mid-cycle right after the grant edge.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    set_in(1'b1, 3'd7, 19'h07777, 1'b1, 3'd7, 19'h03333, 1'b1, 3'd7);
    #1;
    check_state("midrst", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("midrst_addr", 32'(bus.rf_rd_addr_o), 32'h0);
    check("midrst_data", 32'(bus.rf_wr_data_o), 32'h0);
    #5;
    reset_n = 1'b1;
    #1;
    check_state("postrst", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    exp_q.push_back('{rd: 3'd7, data: 19'h07777});

    cycle("c17", 1, 3'd7, 19'h07777, 1, 3'd7, 19'h03333, 0, 3'd0, 0, 1, 1, 8'h80, 0, 1);
    cycle("c18", 0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     0, 3'd0, 0, 0, 1, 8'h00, 0, 1);
    cycle("c19", 0, 3'd0, 19'h0,     0, 3'd0, 19'h0,     0, 3'd0, 0, 0, 0, 8'h00, 1, 1);

    // Bounded drain of any outstanding expected writes.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
